// File: rtl/mux_pack_n.sv
// Parametrised narrow-to-wide lane packer with valid/ready flow control, one-word output
// register, selectable lane order and zero-padded flush. Optional overflow counter: MUX_PACK_OVF_EN.
module mux_pack_n #(
  parameter int DATA_W    = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = $clog2(RATIO + 1)
) (
  input  logic                    clk_f,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    flush,
  output logic [RATIO*DATA_W-1:0] data_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [CNT_W-1:0]        lanes_out,
  output logic [CNT_W-1:0]        fill_count
`ifdef MUX_PACK_OVF_EN
  ,
  output logic [7:0]              ovf_cnt
`endif
);

  localparam int OUT_W = RATIO * DATA_W;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [DATA_W-1:0] r_lane [RATIO];
  logic [CNT_W-1:0]  r_fill;
  logic [CNT_W-1:0]  r_lanes;
  logic [OUT_W-1:0]  r_data;
  logic              r_valid;

  logic              w_slot_free;
  logic              w_ready;
  logic              w_accept;
  logic              w_full;
  logic              w_flush;
  logic              w_emit;
  logic [CNT_W-1:0]  w_lanes_new;
  logic [DATA_W-1:0] w_lane_next [RATIO];
  logic [OUT_W-1:0]  w_word;

  // Only the beat that would complete a word can be stalled by a held output.
  assign w_slot_free = !r_valid || ready_in;
  assign w_ready     = !((r_fill == LAST_LANE) && !w_slot_free);
  assign w_accept    = valid_in && w_ready;
  assign w_full      = w_accept && (r_fill == LAST_LANE);
  assign w_flush     = flush && w_slot_free && ((r_fill != '0) || w_accept);
  assign w_emit      = w_full || w_flush;
  assign w_lanes_new = w_accept ? (r_fill + CNT_W'(1)) : r_fill;

  // Lanes beyond the fill level are forced to zero so a flushed word is zero-padded.
  always_comb begin
    for (int i = 0; i < RATIO; i++) begin
      w_lane_next[i] = '0;
      if (w_accept && (r_fill == CNT_W'(i))) begin
        w_lane_next[i] = data_in;
      end else if (CNT_W'(i) < r_fill) begin
        w_lane_next[i] = r_lane[i];
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (MSB_FIRST != 0) begin
        w_word[OUT_W-1-i*DATA_W -: DATA_W] = w_lane_next[i];
      end else begin
        w_word[i*DATA_W +: DATA_W] = w_lane_next[i];
      end
    end
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      r_fill  <= '0;
      r_lanes <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < RATIO; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RATIO; i++) begin
        if (w_accept && (r_fill == CNT_W'(i))) begin
          r_lane[i] <= data_in;
        end
      end
      if (w_emit) begin
        r_data  <= w_word;
        r_lanes <= w_lanes_new;
        r_valid <= 1'b1;
        r_fill  <= '0;
      end else begin
        if (ready_in) begin
          r_valid <= 1'b0;
        end
        r_fill <= w_lanes_new;
      end
    end
  end

`ifdef MUX_PACK_OVF_EN
  logic [7:0] r_ovf;

  // Counts offered-but-refused beats, saturating at all-ones.
  always_ff @(posedge clk_f) begin
    if (!reset) begin
      r_ovf <= '0;
    end else if (valid_in && !w_ready && (r_ovf != 8'hFF)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf;
`endif

  assign ready_out  = w_ready;
  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign lanes_out  = r_lanes;
  assign fill_count = r_fill;

endmodule

// File: tb/tb_mux_pack_n.sv
// Self-checking bench for mux_pack_n: MSB-first and LSB-first instances driven in parallel,
// checked against a queue-based reference model, a vector table and hand-written sequences.
module tb_mux_pack_n;

  localparam int RATIO = 4;

  logic        clk_f = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        flush;
  logic        ready_in;

  logic        readyM, validM, readyL, validL;
  logic [31:0] dataM, dataL;
  logic [2:0]  lanesM, fillM, lanesL, fillL;
`ifdef MUX_PACK_OVF_EN
  logic [7:0]  ovfM, ovfL;
`endif

  int nVec = 0;
  int nMis = 0;

  // Reference model: accepted beats waiting in a queue, plus the output slot.
  logic [7:0]  mBeats[$];
  logic        mValid = 1'b0;
  logic [31:0] mWordM = '0;
  logic [31:0] mWordL = '0;
  int          mLanes = 0;
  int          mOvf = 0;
  logic        mReady;

  typedef struct {
    logic        vin;
    logic [7:0]  din;
    logic        fl;
    logic        rin;
    logic        expValid;
    logic [31:0] expData;
    logic [2:0]  expLanes;
    logic [2:0]  expFill;
  } vec_t;

  vec_t vecs[13];

  always #5 clk_f = ~clk_f;

  mux_pack_n #(.DATA_W(8), .RATIO(RATIO), .MSB_FIRST(1)) dutM (
    .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(readyM), .flush(flush), .data_out(dataM), .valid_out(validM),
    .ready_in(ready_in), .lanes_out(lanesM), .fill_count(fillM)
`ifdef MUX_PACK_OVF_EN
    , .ovf_cnt(ovfM)
`endif
  );

  mux_pack_n #(.DATA_W(8), .RATIO(RATIO), .MSB_FIRST(0)) dutL (
    .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(readyL), .flush(flush), .data_out(dataL), .valid_out(validL),
    .ready_in(ready_in), .lanes_out(lanesL), .fill_count(fillL)
`ifdef MUX_PACK_OVF_EN
    , .ovf_cnt(ovfL)
`endif
  );

  function automatic logic [31:0] packWord(input bit msbFirst);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < mBeats.size(); k++) begin
      if (msbFirst) w = w | (32'(mBeats[k]) << (32 - 8 * (k + 1)));
      else          w = w | (32'(mBeats[k]) << (8 * k));
    end
    return w;
  endfunction

  task automatic modelStep(input logic rst, input logic vin, input logic [7:0] din,
                           input logic fl, input logic rin);
    bit slot;
    bit rdy;
    if (!rst) begin
      mBeats.delete();
      mValid = 1'b0;
      mWordM = '0;
      mWordL = '0;
      mLanes = 0;
      mOvf   = 0;
      return;
    end
    slot = !mValid || rin;
    rdy  = !(mBeats.size() == RATIO - 1 && !slot);
    if (vin && !rdy && mOvf < 255) mOvf++;
    if (vin && rdy) mBeats.push_back(din);
    if (mBeats.size() == RATIO || (fl && slot && mBeats.size() > 0)) begin
      mWordM = packWord(1'b1);
      mWordL = packWord(1'b0);
      mLanes = mBeats.size();
      mValid = 1'b1;
      mBeats.delete();
    end else if (rin) begin
      mValid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready before the edge, check registers after it.
  task automatic applyStimulus(input logic rst, input logic vin, input logic [7:0] din,
                               input logic fl, input logic rin);
    reset    = rst;
    valid_in = vin;
    data_in  = din;
    flush    = fl;
    ready_in = rin;
    #1;
    mReady = !(mBeats.size() == RATIO - 1 && !(!mValid || rin));
    checkOutput("ready_msb", 32'(readyM), 32'(mReady));
    checkOutput("ready_lsb", 32'(readyL), 32'(mReady));
    @(posedge clk_f);
    modelStep(rst, vin, din, fl, rin);
    #1;
    checkOutput("valid_msb", 32'(validM), 32'(mValid));
    checkOutput("data_msb",  dataM, mWordM);
    checkOutput("lanes_msb", 32'(lanesM), 32'(mLanes));
    checkOutput("fill_msb",  32'(fillM), 32'(mBeats.size()));
    checkOutput("valid_lsb", 32'(validL), 32'(mValid));
    checkOutput("data_lsb",  dataL, mWordL);
    checkOutput("lanes_lsb", 32'(lanesL), 32'(mLanes));
    checkOutput("fill_lsb",  32'(fillL), 32'(mBeats.size()));
`ifdef MUX_PACK_OVF_EN
    checkOutput("ovf_msb", 32'(ovfM), 32'(mOvf));
    checkOutput("ovf_lsb", 32'(ovfL), 32'(mOvf));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 3'd1};
    vecs[1]  = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 3'd2};
    vecs[2]  = '{1'b1, 8'hCC, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 3'd3};
    vecs[3]  = '{1'b1, 8'hDD, 1'b0, 1'b1, 1'b1, 32'hAABB_CCDD, 3'd4, 3'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'hAABB_CCDD, 3'd4, 3'd0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'hAABB_CCDD, 3'd4, 3'd1};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'hAABB_CCDD, 3'd4, 3'd2};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h1122_0000, 3'd2, 3'd0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h1122_0000, 3'd2, 3'd0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h1122_0000, 3'd2, 3'd0};
    vecs[10] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h1122_0000, 3'd2, 3'd1};
    vecs[11] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 32'h3344_0000, 3'd2, 3'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h3344_0000, 3'd2, 3'd0};

    // Reset held for two cycles, then released.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("reset_data",  dataM, 32'h0);
    checkOutput("reset_valid", 32'(validM), 32'h0);
    checkOutput("reset_fill",  32'(fillM), 32'h0);
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(readyM), 32'h1);

    // Full word, then flush cases, from the vector table.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, vecs[i].vin, vecs[i].din, vecs[i].fl, vecs[i].rin);
      checkOutput($sformatf("vec%0d_valid", i), 32'(validM), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_data", i), dataM, vecs[i].expData);
      checkOutput($sformatf("vec%0d_lanes", i), 32'(lanesM), 32'(vecs[i].expLanes));
      checkOutput($sformatf("vec%0d_fill", i), 32'(fillM), 32'(vecs[i].expFill));
    end

    // Backpressure: first word held, lanes 0..2 of the next still accepted, last beat stalled.
    for (int b = 1; b <= 7; b++) begin
      applyStimulus(1'b1, 1'b1, 8'(b), 1'b0, 1'b0);
      if (b >= 4) begin
        checkOutput("bp_held_data", dataM, 32'h0102_0304);
        checkOutput("bp_held_valid", 32'(validM), 32'h1);
      end
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 8'h08, 1'b0, 1'b0);
      checkOutput("bp_stall_ready", 32'(readyM), 32'h0);
      checkOutput("bp_stall_fill", 32'(fillM), 32'h3);
      checkOutput("bp_stall_data", dataM, 32'h0102_0304);
    end
    applyStimulus(1'b1, 1'b1, 8'h08, 1'b0, 1'b1);
    checkOutput("bp_second_data", dataM, 32'h0506_0708);
    checkOutput("bp_second_valid", 32'(validM), 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("bp_drained", 32'(validM), 32'h0);

    // LSB lane order, then reset in the middle of a word (reset wins over a beat).
    for (int b = 1; b <= 4; b++) applyStimulus(1'b1, 1'b1, 8'(b), 1'b0, 1'b1);
    checkOutput("lsb_word", dataL, 32'h0403_0201);
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
    checkOutput("midrst_fill", 32'(fillM), 32'h0);
    for (int b = 1; b <= 4; b++) applyStimulus(1'b1, 1'b1, 8'hB0 + 8'(b), 1'b0, 1'b1);
    checkOutput("midrst_msb", dataM, 32'hB1B2_B3B4);
    checkOutput("midrst_lsb", dataL, 32'hB4B3_B2B1);
    checkOutput("midrst_lanes", 32'(lanesM), 32'h4);

    // Randomised traffic with occasional reset, flush and backpressure.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                    8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) != 0);
    end

    // Long stall with the downstream blocked.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) applyStimulus(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    checkOutput("stall_ready", 32'(readyM), 32'h0);
    checkOutput("stall_fill", 32'(fillM), 32'h3);
`ifdef MUX_PACK_OVF_EN
    checkOutput("ovf_saturated", 32'(ovfM), 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
